// File: rtl/demux_seq_1_n_if.sv
// Bus bundle for demux_seq_1_n: routed data, select/strobe/mode inputs and channel outputs.
// The controller drives through the master modport; the demux uses the slave modport.
interface demux_seq_1_n_if #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 1
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [DATA_W-1:0]          A;
    logic [SEL_W-1:0]           input_sel;
    logic                       load;
    logic                       mode;
    logic [CHANNELS*DATA_W-1:0] out;
    logic [SEL_W-1:0]           active_sel;
    logic                       valid;
    logic                       sel_err;

    modport master (
        output A, input_sel, load, mode,
        input  out, active_sel, valid, sel_err
    );

    modport slave (
        input  A, input_sel, load, mode,
        output out, active_sel, valid, sel_err
    );
endinterface

// File: rtl/demux_seq_1_n.sv
// Registered 1-to-N demultiplexer with manual select and round-robin auto-scan.
// Define DEMUX_SEQ_BLANK_EN to insert a one-cycle all-zero blank between scan channels.
module demux_seq_1_n #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 1,
    parameter int DWELL    = 4
) (
    input  logic           clk,
    input  logic           reset,
    demux_seq_1_n_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0]  DW_ONE   = DW_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2,
        ST_BLANK  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [SEL_W-1:0]           active_sel_q, active_sel_d;
    logic [SEL_W-1:0]           next_sel_s, chan_idx_s;
    logic [DW_W-1:0]            dwell_q, dwell_d;
    logic [CHANNELS*DATA_W-1:0] out_q, out_d;
    logic                       valid_q, valid_d;
    logic                       sel_err_q, sel_err_d;
    logic                       sel_legal_s;

    // Next state, select, dwell and the output word registered on the coming edge.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        dwell_d      = dwell_q;
        sel_err_d    = sel_err_q;
        out_d        = '0;
        sel_legal_s  = ({1'b0, bus.input_sel} < SEL_LIM);

        if (active_sel_q == SEL_LAST) begin
            next_sel_s = '0;
        end else begin
            next_sel_s = active_sel_q + SEL_ONE;
        end

        case (state_q)
            ST_IDLE, ST_MANUAL: begin
                if (bus.mode) begin
                    state_d = ST_SCAN;
                    dwell_d = '0;
                end else if (bus.load && sel_legal_s) begin
                    state_d      = ST_MANUAL;
                    active_sel_d = bus.input_sel;
                end else if (bus.load) begin
                    sel_err_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SCAN: begin
                if (!bus.mode) begin
                    state_d = ST_MANUAL;
                    dwell_d = '0;
                end else if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
`ifdef DEMUX_SEQ_BLANK_EN
                    state_d = ST_BLANK;
`else
                    active_sel_d = next_sel_s;
`endif
                end else begin
                    dwell_d = dwell_q + DW_ONE;
                end
            end
            ST_BLANK: begin
                dwell_d = '0;
                if (!bus.mode) begin
                    state_d = ST_MANUAL;
                end else begin
                    state_d      = ST_SCAN;
                    active_sel_d = next_sel_s;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                active_sel_d = '0;
                dwell_d      = '0;
            end
        endcase

        // Select k drives channel CHANNELS-1-k; every other channel is held at zero.
        valid_d    = (state_d == ST_MANUAL) || (state_d == ST_SCAN);
        chan_idx_s = SEL_LAST - active_sel_d;
        for (int k = 0; k < CHANNELS; k++) begin
            if (valid_d && (chan_idx_s == SEL_W'(k))) begin
                out_d[k*DATA_W +: DATA_W] = bus.A;
            end else begin
                out_d[k*DATA_W +: DATA_W] = '0;
            end
        end
    end

    // State and output registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            active_sel_q <= '0;
            dwell_q      <= '0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            dwell_q      <= dwell_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.active_sel = active_sel_q;
    assign bus.valid      = valid_q;
    assign bus.sel_err    = sel_err_q;
endmodule

// File: tb/tb_demux_seq_1_n.sv
// Directed bench for demux_seq_1_n: a 4-channel x1 instance (DWELL=4) and a 5-channel x2 instance (DWELL=2).
// Scan expectations follow DEMUX_SEQ_BLANK_EN when the bench is built with it.
module tb_demux_seq_1_n;
    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    demux_seq_1_n_if #(.CHANNELS(4), .DATA_W(1)) if4 ();
    demux_seq_1_n_if #(.CHANNELS(5), .DATA_W(2)) if5 ();

    demux_seq_1_n #(.CHANNELS(4), .DATA_W(1), .DWELL(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    demux_seq_1_n #(.CHANNELS(5), .DATA_W(2), .DWELL(2)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (if5)
    );

`ifdef DEMUX_SEQ_BLANK_EN
    int scan4_sel [17] = '{0,0,0,0,0, 1,1,1,1,1, 2,2,2,2,2, 3,3};
    int scan4_vld [17] = '{1,1,1,1,0, 1,1,1,1,0, 1,1,1,1,0, 1,1};
    int scan5_sel [13] = '{1,1,1, 2,2,2, 3,3,3, 4,4,4, 0};
    int scan5_vld [13] = '{1,1,0, 1,1,0, 1,1,0, 1,1,0, 1};
    int ticks_to_ch2_d2 = 13;
`else
    int scan4_sel [17] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0};
    int scan4_vld [17] = '{1,1,1,1, 1,1,1,1, 1,1,1,1, 1,1,1,1, 1};
    int scan5_sel [13] = '{1,1, 2,2, 3,3, 4,4, 0,0, 1,1, 2};
    int scan5_vld [13] = '{1,1, 1,1, 1,1, 1,1, 1,1, 1,1, 1};
    int ticks_to_ch2_d2 = 11;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_out;

        reset         = 1'b1;
        if4.A         = 1'b0;
        if4.input_sel = 2'd0;
        if4.load      = 1'b0;
        if4.mode      = 1'b0;
        if5.A         = 2'b00;
        if5.input_sel = 3'd0;
        if5.load      = 1'b0;
        if5.mode      = 1'b0;

        // Reset, then hold reset while loads are presented.
        tick();
        tick();
        chk("rst_out4",   32'(if4.out),        32'h0);
        chk("rst_vld4",   32'(if4.valid),      32'h0);
        chk("rst_sel4",   32'(if4.active_sel), 32'h0);
        chk("rst_err4",   32'(if4.sel_err),    32'h0);
        chk("rst_out5",   32'(if5.out),        32'h0);
        chk("rst_err5",   32'(if5.sel_err),    32'h0);
        if4.A = 1'b1; if4.load = 1'b1; if4.input_sel = 2'd2;
        if5.A = 2'b11; if5.load = 1'b1; if5.input_sel = 3'd6;
        tick();
        chk("rsthold_out4", 32'(if4.out),        32'h0);
        chk("rsthold_vld4", 32'(if4.valid),      32'h0);
        chk("rsthold_sel4", 32'(if4.active_sel), 32'h0);
        chk("rsthold_err5", 32'(if5.sel_err),    32'h0);

        // Manual routing with the reversed index mapping.
        reset = 1'b0;
        if5.load = 1'b0;
        if4.A = 1'b1; if4.load = 1'b1; if4.input_sel = 2'd0;
        tick();
        chk("man0_sel", 32'(if4.active_sel), 32'h0);
        chk("man0_out", 32'(if4.out),        32'h8);
        chk("man0_vld", 32'(if4.valid),      32'h1);
        if4.input_sel = 2'd3;
        tick();
        chk("man3_sel", 32'(if4.active_sel), 32'h3);
        chk("man3_out", 32'(if4.out),        32'h1);
        if4.load = 1'b0; if4.A = 1'b0;
        tick();
        chk("manA0_out", 32'(if4.out),   32'h0);
        chk("manA0_vld", 32'(if4.valid), 32'h1);
        if4.A = 1'b1; if4.load = 1'b1; if4.input_sel = 2'd0;
        tick();
        chk("man0b_out", 32'(if4.out), 32'h8);

        // Auto-scan on the 4-channel instance starting from channel select 0.
        if4.load = 1'b0; if4.mode = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_out = (scan4_vld[i] != 0) ? (32'h8 >> scan4_sel[i]) : 32'h0;
            chk($sformatf("scan4_sel[%0d]", i), 32'(if4.active_sel), 32'(scan4_sel[i]));
            chk($sformatf("scan4_vld[%0d]", i), 32'(if4.valid),      32'(scan4_vld[i]));
            chk($sformatf("scan4_out[%0d]", i), 32'(if4.out),        exp_out);
        end
        if4.mode = 1'b0;
        tick();
        tick();
        chk("scan2man_sel", 32'(if4.active_sel), 32'(scan4_sel[16]));
        chk("scan2man_vld", 32'(if4.valid),      32'h1);
        chk("scan2man_out", 32'(if4.out),        32'h8 >> scan4_sel[16]);

        // Illegal selects on the 5-channel instance; sel_err is sticky.
        if5.A = 2'b11; if5.load = 1'b1; if5.input_sel = 3'd6;
        tick();
        chk("ill6_err", 32'(if5.sel_err),    32'h1);
        chk("ill6_sel", 32'(if5.active_sel), 32'h0);
        chk("ill6_vld", 32'(if5.valid),      32'h0);
        if5.input_sel = 3'd4;
        tick();
        chk("leg4_sel", 32'(if5.active_sel), 32'h4);
        chk("leg4_out", 32'(if5.out),        32'h003);
        chk("leg4_err", 32'(if5.sel_err),    32'h1);
        if5.input_sel = 3'd5;
        tick();
        chk("ill5_sel", 32'(if5.active_sel), 32'h4);
        chk("ill5_out", 32'(if5.out),        32'h003);
        if5.A = 2'b10; if5.input_sel = 3'd1;
        tick();
        chk("leg1_sel", 32'(if5.active_sel), 32'h1);
        chk("leg1_out", 32'(if5.out),        32'h080);

        // Auto-scan on the 5-channel instance from channel select 1, DWELL=2.
        if5.A = 2'b01; if5.load = 1'b0; if5.mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            exp_out = (scan5_vld[i] != 0) ? (32'h1 << ((4 - scan5_sel[i]) * 2)) : 32'h0;
            chk($sformatf("scan5_sel[%0d]", i), 32'(if5.active_sel), 32'(scan5_sel[i]));
            chk($sformatf("scan5_vld[%0d]", i), 32'(if5.valid),      32'(scan5_vld[i]));
            chk($sformatf("scan5_out[%0d]", i), 32'(if5.out),        exp_out);
        end
        chk("err5_sticky", 32'(if5.sel_err), 32'h1);
        if5.mode = 1'b0;

        // Reset in the middle of a scan window, then mode+load together.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if4.A = 1'b1; if4.mode = 1'b1; if4.load = 1'b0;
        for (int i = 0; i < ticks_to_ch2_d2; i++) begin
            tick();
        end
        chk("mid_sel", 32'(if4.active_sel), 32'h2);
        chk("mid_out", 32'(if4.out),        32'h2);
        reset = 1'b1; if4.load = 1'b1; if4.input_sel = 2'd3;
        tick();
        chk("midrst_out", 32'(if4.out),        32'h0);
        chk("midrst_sel", 32'(if4.active_sel), 32'h0);
        chk("midrst_vld", 32'(if4.valid),      32'h0);
        chk("midrst_err5", 32'(if5.sel_err),   32'h0);
        reset = 1'b0;
        tick();
        chk("modeload_sel", 32'(if4.active_sel), 32'h0);
        chk("modeload_vld", 32'(if4.valid),      32'h1);
        chk("modeload_out", 32'(if4.out),        32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
